// File: rtl/sys_bridge_n_if.sv
// sys_bridge_n_if -- CPU data-port bus between the processor and sys_bridge_n.
//
// Signals:
//   PrAddr    [31:2]  CPU word address
//   PrWD      [31:0]  CPU write data
//   PrReq             access valid this cycle
//   PrWrite           1 = write, 0 = read (qualified by PrReq)
//   PrRD      [31:0]  registered read data (bridge -> CPU)
//   PrRDValid         one-cycle pulse, PrRD valid
//   PrErr             one-cycle pulse, unmapped access
//
// Modports: master = CPU side, slave = bridge side.
interface sys_bridge_n_if;
    logic [31:2] PrAddr;
    logic [31:0] PrWD;
    logic        PrReq;
    logic        PrWrite;
    logic [31:0] PrRD;
    logic        PrRDValid;
    logic        PrErr;

    modport master (
        output PrAddr, PrWD, PrReq, PrWrite,
        input  PrRD, PrRDValid, PrErr
    );

    modport slave (
        input  PrAddr, PrWD, PrReq, PrWrite,
        output PrRD, PrRDValid, PrErr
    );
endinterface

// File: rtl/sys_bridge_n.sv
// sys_bridge_n -- system bridge between the CPU data port and up to five
// memory-mapped peripherals, plus a local interrupt block driving HWInt[7:2].
//
// Address map (16-byte windows starting at DEV_BASE):
//   DEV_BASE + 16*i     device i, word offsets 0..2 (offset 3 unmapped)
//   LOC = DEV_BASE + 16*NUM_DEV:
//     +0 IRQ_PEND  bits [NUM_DEV:0], ext_irq at bit NUM_DEV
//     +4 IRQ_MASK  RW, same width, resets to all ones
//     +8 ERR_CNT   16-bit saturating unmapped-access counter, any write clears
//     +C unmapped
//
// Ports:
//   clk, reset_n      clock, asynchronous active-low reset
//   cpu               CPU bus (sys_bridge_n_if.slave)
//   dev_RD            per-device read data, device i at [32i+31:32i]
//   dev_IRQ           per-device interrupt requests
//   ext_irq           external interrupt line
//   dev_WE            per-device write enable (combinational)
//   dev_Addr, dev_WD  pass-through of PrAddr / PrWD
//   HWInt[7:2]        interrupt lines to CP0 (pend & mask)
//
// Build option: BRIDGE_IRQ_EDGE_EN
//   defined   -> IRQ_PEND bits set on rising input edges, write-1-to-clear
//                at LOC+0, set wins over a same-cycle clear.
//   undefined -> IRQ_PEND is a registered copy of {ext_irq, dev_IRQ};
//                writes to LOC+0 are accepted and ignored.
module sys_bridge_n #(
    parameter int unsigned NUM_DEV  = 2,
    parameter logic [31:0] DEV_BASE = 32'h0000_7F00
) (
    input  logic                   clk,
    input  logic                   reset_n,
    sys_bridge_n_if.slave          cpu,
    input  logic [NUM_DEV*32-1:0]  dev_RD,
    input  logic [NUM_DEV-1:0]     dev_IRQ,
    input  logic                   ext_irq,
    output logic [NUM_DEV-1:0]     dev_WE,
    output logic [31:2]            dev_Addr,
    output logic [31:0]            dev_WD,
    output logic [7:2]             HWInt
);

    localparam int unsigned IW     = NUM_DEV + 1;
    localparam logic [27:0] BASE_W = DEV_BASE[31:4];
    localparam logic [27:0] LOC_W  = BASE_W + 28'(NUM_DEV);

    // Word offset inside a 16-byte window.
    typedef enum logic [1:0] {
        OFF_PEND = 2'd0,
        OFF_MASK = 2'd1,
        OFF_ERR  = 2'd2,
        OFF_NONE = 2'd3
    } win_off_t;

    win_off_t          off;
    logic [NUM_DEV-1:0] hit;
    logic              loc_win;
    logic              wr_req;
    logic              rd_req;
    logic              unmapped;
    logic              wr_mask;
    logic              wr_err;
    logic [31:0]       rd_mux;
    logic [IW-1:0]     irq_in;

    logic [IW-1:0]     pend;
    logic [IW-1:0]     mask;
    logic [15:0]       err_cnt;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    always_comb begin
        off     = win_off_t'(cpu.PrAddr[3:2]);
        hit     = '0;
        for (int unsigned i = 0; i < NUM_DEV; i++) begin
            hit[i] = (cpu.PrAddr[31:4] == BASE_W + 28'(i)) && (off != OFF_NONE);
        end
        loc_win = (cpu.PrAddr[31:4] == LOC_W) && (off != OFF_NONE);
    end

    assign wr_req   = cpu.PrReq & cpu.PrWrite;
    assign rd_req   = cpu.PrReq & ~cpu.PrWrite;
    assign unmapped = cpu.PrReq & ~(|hit) & ~loc_win;
    assign wr_mask  = wr_req & loc_win & (off == OFF_MASK);
    assign wr_err   = wr_req & loc_win & (off == OFF_ERR);
    assign irq_in   = {ext_irq, dev_IRQ};

    // Devices sample the write on the same edge as the request.
    assign dev_WE   = {NUM_DEV{wr_req}} & hit;
    assign dev_Addr = cpu.PrAddr;
    assign dev_WD   = cpu.PrWD;

    // ------------------------------------------------------------------
    // Read source select; unmapped reads return the AAAA filler
    // ------------------------------------------------------------------
    always_comb begin
        rd_mux = 32'hAAAA_AAAA;
        for (int unsigned i = 0; i < NUM_DEV; i++) begin
            if (hit[i]) begin
                rd_mux = dev_RD[32*i +: 32];
            end
        end
        if (loc_win) begin
            case (off)
                OFF_PEND: rd_mux = 32'(pend);
                OFF_MASK: rd_mux = 32'(mask);
                OFF_ERR:  rd_mux = 32'(err_cnt);
                default:  rd_mux = 32'hAAAA_AAAA;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Registered read response; PrRD holds between reads
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cpu.PrRD      <= '0;
            cpu.PrRDValid <= 1'b0;
            cpu.PrErr     <= 1'b0;
        end else begin
            cpu.PrRDValid <= rd_req;
            cpu.PrErr     <= unmapped;
            if (rd_req) begin
                cpu.PrRD <= rd_mux;
            end
        end
    end

    // ------------------------------------------------------------------
    // Error counter (saturating) and interrupt mask
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_cnt <= '0;
        end else if (wr_err) begin
            err_cnt <= '0;
        end else if (unmapped && (err_cnt != '1)) begin
            err_cnt <= err_cnt + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mask <= '1;
        end else if (wr_mask) begin
            mask <= cpu.PrWD[IW-1:0];
        end
    end

    // ------------------------------------------------------------------
    // Interrupt pending
    // ------------------------------------------------------------------
`ifdef BRIDGE_IRQ_EDGE_EN
    logic          wr_pend;
    logic [IW-1:0] irq_prev;
    logic [IW-1:0] pend_clr;

    assign wr_pend  = wr_req & loc_win & (off == OFF_PEND);
    assign pend_clr = wr_pend ? cpu.PrWD[IW-1:0] : '0;

    // Clear is applied first so a coincident rising edge re-sets the bit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend     <= '0;
            irq_prev <= '0;
        end else begin
            pend     <= (pend & ~pend_clr) | (irq_in & ~irq_prev);
            irq_prev <= irq_in;
        end
    end
`else
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend <= '0;
        end else begin
            pend <= irq_in;
        end
    end
`endif

    always_comb begin
        HWInt         = '0;
        HWInt[2 +: IW] = pend & mask;
    end

endmodule

// File: doc/sys_bridge_n.md
# sys_bridge_n

Parametrised system bridge between the CPU data port and up to five memory-mapped peripherals (timers or similar). It decodes the CPU address into per-device 16-byte windows and fans out write strobes. It returns registered read data with a valid/error handshake and owns a local interrupt block (pending, mask, error counter) that drives the CP0 `HWInt[7:2]` lines.

## Interface
Parameters:
- `NUM_DEV`, 2: number of device windows, legal 1..5.
- `DEV_BASE`, 32'h0000_7F00: byte address of device 0; device i at `DEV_BASE + 16*i`; must be 16-byte aligned.

Ports:
- `clk` in 1: single clock; all state on rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `PrAddr` in [31:2]: CPU word address.
- `PrWD` in 32: CPU write data.
- `PrReq` in 1: access valid this cycle.
- `PrWrite` in 1: 1 = write, 0 = read; qualified by `PrReq`.
- `PrRD` out 32: registered read data.
- `PrRDValid` out 1: one-cycle pulse, `PrRD` valid.
- `PrErr` out 1: one-cycle pulse, unmapped access.
- `dev_RD` in NUM_DEV*32: device read data, device i at bits [32i+31:32i].
- `dev_IRQ` in NUM_DEV: device interrupt requests.
- `ext_irq` in 1: external interrupt line.
- `dev_WE` out NUM_DEV: per-device write enable.
- `dev_Addr` out [31:2], `dev_WD` out 32: pass-through of `PrAddr`/`PrWD`.
- `HWInt` out [7:2]: interrupt lines to CP0.

## Operation
- Device hit i: `PrAddr[31:4] == DEV_BASE[31:4] + i` and `PrAddr[3:2] != 2'b11`. Word offset 3 of every window is unmapped.
- Local block at `LOC = DEV_BASE + 16*NUM_DEV`:
  - +0 `IRQ_PEND`, bits [NUM_DEV:0], ext at bit NUM_DEV.
  - +4 `IRQ_MASK`, RW, same width.
  - +8 `ERR_CNT`, 16-bit, zero-extended on read; any write clears it.
  - +C unmapped.
- Unmapped access means any `PrReq` matching no device and no local register.
- Write: `dev_WE[i] = PrReq & PrWrite & hit_i`, combinational. The device samples on the same edge. Local register writes also take effect on that edge.
- Read: on `PrReq & !PrWrite`, the selected source is registered into `PrRD` and `PrRDValid` = 1 the next cycle. An unmapped read returns 32'hAAAA_AAAA. `PrRD` holds its value until the next read.
- Error handling:
  - Unmapped access: `PrErr` pulses the cycle after the request, with `PrRDValid` if it was a read.
  - No `dev_WE` is raised.
  - `ERR_CNT` increments and saturates at 16'hFFFF.
  - A write to `ERR_CNT` itself is mapped and does not count as an error.
- Interrupts:
  - `HWInt[2+k] = IRQ_PEND[k] & IRQ_MASK[k]` for k = 0..NUM_DEV; higher `HWInt` bits are 0.
  - Pending update is per Configuration.
- Back-to-back requests are legal every cycle; there are no stalls.

## Timing
- Reset values: `PrRD`=0, `PrRDValid`=0, `PrErr`=0, `IRQ_PEND`=0, `IRQ_MASK`=all ones, `ERR_CNT`=0, edge-history registers=0, so `HWInt`=0.
- Read latency is 1 cycle. Write takes effect at the request edge.
- IRQ input to `HWInt`: 1 cycle (registered pend, combinational mask AND).
- Reset mid-read: the pending `PrRDValid` is discarded.

## Configuration
- `BRIDGE_IRQ_EDGE_EN` defined:
  - `IRQ_PEND[k]` sets on a rising edge of its input (previous-cycle sample 0, current 1).
  - It stays set until software writes 1 to that bit at `LOC+0` (write-1-to-clear).
  - If set and clear occur in the same cycle, set wins.
- `BRIDGE_IRQ_EDGE_EN` undefined:
  - `IRQ_PEND` is a registered copy of `{ext_irq, dev_IRQ}` every cycle.
  - Writes to `LOC+0` are ignored and are not errors.

## Test plan
- Reset, then NUM_DEV=2, DEV_BASE=0x7F00. Read 0x7F04 with `dev_RD` word1 = 0x1234 -> next cycle `PrRDValid`=1, `PrRD`=0x1234, `PrErr`=0.
- Write 0xDEAD to 0x7F14 -> `dev_WE`=2'b10 in the same cycle, `dev_WD`=0xDEAD. Write to 0x7F0C -> `dev_WE`=0, `PrErr` pulse next cycle, `ERR_CNT`=1.
- Read 0x8000 -> `PrRD`=0xAAAAAAAA, `PrRDValid`=1 and `PrErr`=1 together. Issue 0x10000 unmapped accesses -> `ERR_CNT` reads 0xFFFF. Write `LOC+8` -> it reads 0.
- Write `IRQ_MASK`=3'b101, raise all IRQs -> one cycle later `HWInt`=6'b000101.
- Edge mode: pulse `dev_IRQ[1]` for 1 cycle -> `HWInt[3]` stays 1. Write 3'b010 to `LOC+0` -> it clears. Repeat with the edge coinciding with the clear -> it stays set.
- Level mode: drop `dev_IRQ[0]` -> `HWInt[2]` falls 1 cycle later. Assert `reset_n`=0 mid-read -> `PrRDValid` stays 0.
